// File: rtl/mem_responder_pkg.sv
// Shared defines for the memory responder: RISC-V load/store funct3
// encodings, responder FSM state encoding and a funct3 legality helper.
package mem_responder_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Responder FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // True when funct3 names a real access of the given direction
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = 1'b0;
        if (we) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic for one 32-bit word: load extraction with
// sign/zero extension, store byte enables with replicated lane data, and
// the misalignment / illegal-funct3 error flag.
module mem_lane_align
    import mem_responder_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_ldata,
    output logic [3:0]  o_be,
    output logic [31:0] o_sdata,
    output logic        o_err
);

    logic       w_misal;
    logic       w_illegal;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    // Size-dependent alignment check; funct3[1:0] gives the access size
    always_comb begin
        w_misal = 1'b0;
        case (i_func3[1:0])
            2'b01:   w_misal = i_addr_lo[0];
            2'b10:   w_misal = |i_addr_lo;
            default: w_misal = 1'b0;
        endcase
    end

    assign w_illegal = !f3_legal(i_we, i_func3);
    assign o_err     = w_illegal || w_misal;

    assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    // Load result; zero for stores and for any erroring access
    always_comb begin
        o_ldata = 32'd0;
        if (!i_we && !o_err) begin
            case (i_func3)
                F3_LB:   o_ldata = {{24{w_byte[7]}}, w_byte};
                F3_LBU:  o_ldata = {24'd0, w_byte};
                F3_LH:   o_ldata = {{16{w_half[15]}}, w_half};
                F3_LHU:  o_ldata = {16'd0, w_half};
                F3_LW:   o_ldata = i_rword;
                default: o_ldata = 32'd0;
            endcase
        end
    end

    // Store lanes: data is replicated across lanes so only the enables
    // depend on the address
    always_comb begin
        o_be    = 4'b0000;
        o_sdata = 32'd0;
        if (i_we && !o_err) begin
            case (i_func3)
                F3_SB: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_sdata = {4{i_wdata[7:0]}};
                end
                F3_SH: begin
                    o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_sdata = {2{i_wdata[15:0]}};
                end
                F3_SW: begin
                    o_be    = 4'b1111;
                    o_sdata = i_wdata;
                end
                default: begin
                    o_be    = 4'b0000;
                    o_sdata = 32'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Byte-addressed memory responder with fixed response latency.
// Handshake: a request is taken on a rising edge with req_valid & req_ready;
// a response is released on a rising edge with rsp_valid & rsp_ready, and
// rsp_rdata/rsp_err hold steady while rsp_valid waits for rsp_ready.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        dbg_state
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;

    logic                r_we;
    logic [2:0]          r_func3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_err;
    logic [7:0]          r_mem [DEPTH];

    logic                w_idle;
    logic                w_accept;
    logic                w_commit;
    logic                w_we;
    logic [2:0]          w_func3;
    logic [ADDR_W-1:0]   w_addr;
    logic [ADDR_W-1:0]   w_base;
    logic [31:0]         w_wdata;
    logic [31:0]         w_rword;
    logic [31:0]         w_ldata;
    logic [31:0]         w_sdata;
    logic [3:0]          w_be;
    logic                w_err;

    assign w_idle    = (r_state == S_IDLE);
    // Not ready while reset is held, so nothing is accepted under reset
    assign req_ready = w_idle && rst;
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign dbg_state = r_state;

    // With LATENCY=1 the commit edge is the accept edge, before the capture
    // registers are loaded, so in IDLE the live request fields are used
    assign w_we    = w_idle ? req_we    : r_we;
    assign w_func3 = w_idle ? req_func3 : r_func3;
    assign w_addr  = w_idle ? req_addr  : r_addr;
    assign w_wdata = w_idle ? req_wdata : r_wdata;

    assign w_base  = {w_addr[ADDR_W-1:2], 2'b00};
    assign w_rword = {r_mem[w_base + ADDR_W'(3)], r_mem[w_base + ADDR_W'(2)],
                      r_mem[w_base + ADDR_W'(1)], r_mem[w_base]};

    assign w_commit = (w_accept && (LATENCY == 1)) ||
                      ((r_state == S_WAIT) && (r_cnt == 4'd0));

    mem_lane_align u_align (
        .i_we      (w_we),
        .i_func3   (w_func3),
        .i_addr_lo (w_addr[1:0]),
        .i_rword   (w_rword),
        .i_wdata   (w_wdata),
        .o_ldata   (w_ldata),
        .o_be      (w_be),
        .o_sdata   (w_sdata),
        .o_err     (w_err)
    );

    // Next state and countdown
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State and countdown registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture the request on acceptance; held until the next acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_func3 <= 3'd0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_func3 <= req_func3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Response registers, loaded on the edge entering RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else if (w_commit) begin
            r_rdata <= w_ldata;
            r_err   <= w_err;
        end
    end

    // Byte array write; no reset so contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_base + ADDR_W'(i)] <= w_sdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 4, 1) on one clock.
module tb_mem_responder;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int N_VEC = 29;

    logic        clk;
    logic        rst       [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_we    [3];
    logic [2:0]  req_func3 [3];
    logic [7:0]  req_addr  [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    logic [1:0]  dbg_state [3];

    int n_chk;
    int n_err;
    int cyc;
    vec_t vecs [N_VEC];

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.LATENCY(2), .ADDR_W(8)) u_l2 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_func3(req_func3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .dbg_state(dbg_state[0])
    );

    mem_responder #(.LATENCY(4), .ADDR_W(8)) u_l4 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_func3(req_func3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .dbg_state(dbg_state[1])
    );

    mem_responder #(.LATENCY(1), .ADDR_W(8)) u_l1 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_func3(req_func3[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .dbg_state(dbg_state[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request on instance k with rsp_ready high; returns the
    // response, the accept-to-response latency in cycles and the accept cycle
    task automatic run_req(input int k, input logic we, input logic [2:0] f3,
                           input logic [7:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err,
                           output int lat, output int acc_cyc);
        int n;
        rdata   = 32'd0;
        err     = 1'b0;
        lat     = -1;
        acc_cyc = 0;
        @(negedge clk);
        rsp_ready[k] = 1'b1;
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_func3[k] = f3;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[k]) begin
            n_chk++;
            n_err++;
            $display("FAIL req_ready_timeout: inst %0d never ready", k);
            req_valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        acc_cyc      = cyc;
        req_valid[k] = 1'b0;
        lat = 1;
        while (!rsp_valid[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid[k]) begin
            n_chk++;
            n_err++;
            $display("FAIL rsp_valid_timeout: inst %0d no response", k);
            lat = -1;
            return;
        end
        rdata = rsp_rdata[k];
        err   = rsp_err[k];
        @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc;
        int          acc_prev;
        int          n;

        n_chk = 0;
        n_err = 0;
        cyc   = 0;

        vecs[0]  = '{1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 3'b010, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 3'b000, 8'h13, 32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[3]  = '{1'b0, 3'b100, 8'h13, 32'h0,        32'h000000DE, 1'b0};
        vecs[4]  = '{1'b0, 3'b001, 8'h12, 32'h0,        32'hFFFFDEAD, 1'b0};
        vecs[5]  = '{1'b0, 3'b101, 8'h10, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[6]  = '{1'b1, 3'b001, 8'h11, 32'h00001234, 32'h00000000, 1'b1};
        vecs[7]  = '{1'b0, 3'b010, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[8]  = '{1'b0, 3'b010, 8'h12, 32'h0,        32'h00000000, 1'b1};
        vecs[9]  = '{1'b1, 3'b000, 8'h11, 32'h00000077, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 3'b010, 8'h10, 32'h0,        32'hDEAD77EF, 1'b0};
        vecs[11] = '{1'b1, 3'b001, 8'h12, 32'h0000CAFE, 32'h00000000, 1'b0};
        vecs[12] = '{1'b0, 3'b010, 8'h10, 32'h0,        32'hCAFE77EF, 1'b0};
        vecs[13] = '{1'b0, 3'b001, 8'h10, 32'h0,        32'h000077EF, 1'b0};
        vecs[14] = '{1'b0, 3'b000, 8'h11, 32'h0,        32'h00000077, 1'b0};
        vecs[15] = '{1'b0, 3'b000, 8'h10, 32'h0,        32'hFFFFFFEF, 1'b0};
        vecs[16] = '{1'b0, 3'b011, 8'h10, 32'h0,        32'h00000000, 1'b1};
        vecs[17] = '{1'b0, 3'b110, 8'h10, 32'h0,        32'h00000000, 1'b1};
        vecs[18] = '{1'b1, 3'b010, 8'h14, 32'h01020304, 32'h00000000, 1'b0};
        vecs[19] = '{1'b1, 3'b100, 8'h14, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        vecs[20] = '{1'b1, 3'b010, 8'h16, 32'hAAAAAAAA, 32'h00000000, 1'b1};
        vecs[21] = '{1'b0, 3'b010, 8'h14, 32'h0,        32'h01020304, 1'b0};
        vecs[22] = '{1'b1, 3'b010, 8'hFC, 32'h89ABCDEF, 32'h00000000, 1'b0};
        vecs[23] = '{1'b0, 3'b001, 8'hFE, 32'h0,        32'hFFFF89AB, 1'b0};
        vecs[24] = '{1'b0, 3'b100, 8'hFF, 32'h0,        32'h00000089, 1'b0};
        vecs[25] = '{1'b0, 3'b101, 8'h11, 32'h0,        32'h00000000, 1'b1};
        vecs[26] = '{1'b1, 3'b111, 8'h14, 32'h55555555, 32'h00000000, 1'b1};
        vecs[27] = '{1'b0, 3'b010, 8'h14, 32'h0,        32'h01020304, 1'b0};
        vecs[28] = '{1'b0, 3'b010, 8'h16, 32'h0,        32'h00000000, 1'b1};

        for (int k = 0; k < 3; k++) begin
            rst[k]       = 1'b0;
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_func3[k] = 3'd0;
            req_addr[k]  = 8'd0;
            req_wdata[k] = 32'd0;
            rsp_ready[k] = 1'b1;
        end

        // Reset state
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
            check("reset_rsp_rdata", rsp_rdata[k], 32'd0);
            check("reset_rsp_err",   {31'd0, rsp_err[k]}, 32'd0);
            check("reset_state",     {30'd0, dbg_state[k]}, 32'd0);
            check("reset_req_ready_low", {31'd0, req_ready[k]}, 32'd0);
            rst[k] = 1'b1;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            check("post_reset_req_ready", {31'd0, req_ready[k]}, 32'd1);
        end

        // Directed vectors, LATENCY=2
        for (int i = 0; i < N_VEC; i++) begin
            run_req(0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, acc);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        end

        // Backpressure: response held 5 cycles, stray request ignored
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_func3[0] = 3'b010;
        req_addr[0]  = 8'h10;
        check("bp_req_ready", {31'd0, req_ready[0]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        n = 0;
        while (!rsp_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
            check("bp_rsp_rdata", rsp_rdata[0], 32'hCAFE77EF);
            check("bp_rsp_err",   {31'd0, rsp_err[0]}, 32'd0);
            check("bp_req_ready_low", {31'd0, req_ready[0]}, 32'd0);
            if (i == 2) begin
                req_valid[0] = 1'b1;
                req_we[0]    = 1'b1;
                req_func3[0] = 3'b010;
                req_addr[0]  = 8'h10;
                req_wdata[0] = 32'h00000000;
            end else begin
                req_valid[0] = 1'b0;
            end
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_done_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check("bp_done_req_ready", {31'd0, req_ready[0]}, 32'd1);
        run_req(0, 1'b0, 3'b010, 8'h10, 32'd0, rd, er, lat, acc);
        check("bp_stray_ignored", rd, 32'hCAFE77EF);

        // LATENCY=4: reset mid-WAIT discards a pending store
        run_req(1, 1'b1, 3'b000, 8'h20, 32'h0000005C, rd, er, lat, acc);
        check("l4_sb_latency", 32'(lat), 32'd4);
        check("l4_sb_err", {31'd0, er}, 32'd0);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_func3[1] = 3'b000;
        req_addr[1]  = 8'h20;
        req_wdata[1] = 32'h000000AA;
        check("l4_pending_ready", {31'd0, req_ready[1]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("l4_in_wait", {30'd0, dbg_state[1]}, 32'd1);
        rst[1] = 1'b0;
        #1;
        check("l4_rst_state", {30'd0, dbg_state[1]}, 32'd0);
        check("l4_rst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
        check("l4_rst_req_ready", {31'd0, req_ready[1]}, 32'd0);
        check("l4_rst_rdata", rsp_rdata[1], 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("l4_rst_hold_valid", {31'd0, rsp_valid[1]}, 32'd0);
        rst[1] = 1'b1;
        run_req(1, 1'b0, 3'b100, 8'h20, 32'd0, rd, er, lat, acc);
        check("l4_prior_byte", rd, 32'h0000005C);
        check("l4_lbu_latency", 32'(lat), 32'd4);

        // LATENCY=1: back-to-back requests, one accept every 2 cycles
        run_req(2, 1'b1, 3'b010, 8'h40, 32'h11223344, rd, er, lat, acc_prev);
        check("l1_sw_latency", 32'(lat), 32'd1);
        check("l1_sw_err", {31'd0, er}, 32'd0);
        run_req(2, 1'b0, 3'b010, 8'h40, 32'd0, rd, er, lat, acc);
        check("l1_lw_rdata", rd, 32'h11223344);
        check("l1_lw_latency", 32'(lat), 32'd1);
        check("l1_spacing1", 32'(acc - acc_prev), 32'd2);
        acc_prev = acc;
        run_req(2, 1'b1, 3'b000, 8'h41, 32'h00000099, rd, er, lat, acc);
        check("l1_sb_rdata", rd, 32'd0);
        check("l1_spacing2", 32'(acc - acc_prev), 32'd2);
        acc_prev = acc;
        run_req(2, 1'b0, 3'b010, 8'h40, 32'd0, rd, er, lat, acc);
        check("l1_lw2_rdata", rd, 32'h11229944);
        check("l1_spacing3", 32'(acc - acc_prev), 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
